// File: rtl/core_pkg.sv
// Shared fetch-stage types and constants.
//   fetch_state_e : BOOT / RUN / HALT sequencing of the fetch stage
//   if_id_t       : payload held in the IF/ID pipeline register
// Used by instruction_fetch, instruction_fetch_if and if_id_reg.
package core_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned INSTR_W = 32;

    localparam logic [XLEN-1:0]    RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [INSTR_W-1:0] EBREAK_WORD      = 32'h0010_0073;
    localparam logic [INSTR_W-1:0] NOP_WORD         = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [XLEN-1:0]    pc_plus4;
        logic [INSTR_W-1:0] instr;
    } if_id_t;

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: instruction-memory port, redirect input, decode handshake
// and status flags.
//   master : the fetch stage (drives imem_addr, id_*, halted, err_misaligned)
//   slave  : the environment (memory, branch unit, decode)
interface instruction_fetch_if
    import core_pkg::*;
();

    logic [XLEN-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_data;
    logic               redirect_valid;
    logic [XLEN-1:0]    redirect_target;
    logic               id_ready;
    logic               id_valid;
    logic [XLEN-1:0]    id_pc;
    logic [XLEN-1:0]    id_pc_plus4;
    logic [INSTR_W-1:0] id_instr;
    logic               halted;
    logic               err_misaligned;

    modport master (
        output imem_addr, id_valid, id_pc, id_pc_plus4, id_instr, halted, err_misaligned,
        input  imem_data, redirect_valid, redirect_target, id_ready
    );

    modport slave (
        input  imem_addr, id_valid, id_pc, id_pc_plus4, id_instr, halted, err_misaligned,
        output imem_data, redirect_valid, redirect_target, id_ready
    );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
//   clk, rst_n : clock, async active-low reset (clears valid and payload)
//   load       : capture d and mark valid
//   flush      : drop valid (wins over load); payload is left as-is
//   d / q      : captured instruction payload
//   valid      : register holds a live instruction
module if_id_reg
    import core_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   load,
    input  logic   flush,
    input  if_id_t d,
    output logic   valid,
    output if_id_t q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// PC generation and fetch stage feeding decode through a valid/ready handshake.
//   clk, rst_n : core clock, async active-low reset
//   bus        : instruction_fetch_if.master
//                imem_addr/imem_data      combinational instruction memory port
//                redirect_valid/_target   branch/jump redirect with wrong-path flush
//                id_valid/id_ready/id_*   IF/ID handshake to decode
//                halted, err_misaligned   status (err_misaligned is sticky)
// Parameters: RESET_PC (word-aligned), EBREAK_WORD.
// Optional feature macro FETCH_HALT_ON_EBREAK_EN: when defined, fetching
// EBREAK_WORD delivers it to decode and then halts with the PC left on it.
module instruction_fetch
    import core_pkg::*;
#(
    parameter logic [XLEN-1:0]    RESET_PC    = RESET_PC_DEFAULT,
    parameter logic [INSTR_W-1:0] EBREAK_WORD = core_pkg::EBREAK_WORD
) (
    input  logic                clk,
    input  logic                rst_n,
    instruction_fetch_if.master bus
);

`ifdef FETCH_HALT_ON_EBREAK_EN
    localparam bit HALT_ON_EBREAK = 1'b1;
`else
    localparam bit HALT_ON_EBREAK = 1'b0;
`endif

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            halted_q;
    logic            err_q;

    logic            load_c;
    logic            flush_c;
    logic            err_set_c;
    logic            ebreak_hit_c;
    logic            target_ok_c;
    logic            id_valid_c;
    if_id_t          capture_c;
    if_id_t          id_q;

    assign ebreak_hit_c = HALT_ON_EBREAK && (bus.imem_data == EBREAK_WORD);
    assign target_ok_c  = (bus.redirect_target[1:0] == 2'b00);

    assign capture_c.pc       = pc_q;
    assign capture_c.pc_plus4 = pc_q + XLEN'(4);
    assign capture_c.instr    = bus.imem_data;

    // Next-state, next-PC and IF/ID register control.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        load_c    = 1'b0;
        flush_c   = 1'b0;
        err_set_c = 1'b0;

        unique case (state_q)
            BOOT, RUN: begin
                if (state_q == BOOT) begin
                    state_d = RUN;
                end
                if (bus.redirect_valid) begin
                    // Redirect beats a stall; the held wrong-path instruction is killed.
                    flush_c = 1'b1;
                    if (target_ok_c) begin
                        pc_d = bus.redirect_target;
                    end else begin
                        err_set_c = 1'b1;
                        state_d   = HALT;
                    end
                end else if (state_q == RUN && (!id_valid_c || bus.id_ready)) begin
                    load_c = 1'b1;
                    if (ebreak_hit_c) begin
                        state_d = HALT;
                    end else begin
                        pc_d = pc_q + XLEN'(4);
                    end
                end
            end
            HALT: begin
                // Let decode drain a held instruction, then stay empty.
                flush_c = bus.id_ready;
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // State, PC and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= BOOT;
            pc_q     <= RESET_PC;
            halted_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            halted_q <= (state_d == HALT);
            err_q    <= err_q | err_set_c;
        end
    end

    if_id_reg u_if_id_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load_c),
        .flush (flush_c),
        .d     (capture_c),
        .valid (id_valid_c),
        .q     (id_q)
    );

    assign bus.imem_addr      = pc_q;
    assign bus.id_valid       = id_valid_c;
    assign bus.id_pc          = id_q.pc;
    assign bus.id_pc_plus4    = id_q.pc_plus4;
    assign bus.id_instr       = id_q.instr;
    assign bus.halted         = halted_q;
    assign bus.err_misaligned = err_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized scoreboard bench for instruction_fetch. A reference model of the
// fetch rules predicts each cycle's fetch address, flags and the instruction
// decode will accept; accepted instructions are queued and checked by a
// separate monitor. A second instance starting near the top of the address
// space checks PC wrap-around.
module tb_instruction_fetch;
    import core_pkg::*;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instruction_fetch_if bus ();
    instruction_fetch_if bus2 ();

    instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    instruction_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    logic [31:0] mem [64];

    assign bus.imem_data        = mem[bus.imem_addr[7:2]];
    assign bus2.imem_data       = mem[bus2.imem_addr[7:2]];
    assign bus2.redirect_valid  = 1'b0;
    assign bus2.redirect_target = 32'h0;
    assign bus2.id_ready        = 1'b1;

    int total = 0;
    int bad   = 0;
    exp_t exp_q[$];

    // Reference model state: next fetch address, IF/ID content, status.
    logic [31:0] m_pc;
    logic [31:0] m_spc;
    logic [31:0] m_sinstr;
    bit m_sv, m_started, m_halted, m_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        m_pc      = 32'h0;
        m_spc     = 32'h0;
        m_sinstr  = 32'h0;
        m_sv      = 0;
        m_started = 0;
        m_halted  = 0;
        m_err     = 0;
    endtask

    // Apply one clock edge's worth of fetch rules using the inputs seen at that edge.
    task automatic model_step();
        logic [31:0] word;
        if (m_halted) begin
            if (m_sv && bus.id_ready) m_sv = 0;
        end else if (bus.redirect_valid) begin
            m_sv      = 0;
            m_started = 1;
            if (bus.redirect_target[1:0] == 2'b00) begin
                m_pc = bus.redirect_target;
            end else begin
                m_err    = 1;
                m_halted = 1;
            end
        end else if (!m_started) begin
            m_started = 1;
        end else if (!m_sv || bus.id_ready) begin
            word     = mem[m_pc[7:2]];
            m_sv     = 1;
            m_spc    = m_pc;
            m_sinstr = word;
`ifdef FETCH_HALT_ON_EBREAK_EN
            if (word == EBREAK_WORD) m_halted = 1;
            else m_pc = m_pc + 32'd4;
`else
            m_pc = m_pc + 32'd4;
`endif
        end
    endtask

    // Monitor: per-cycle status comparisons plus scoreboard pops on handshakes.
    always @(negedge clk) begin
        exp_t e;
        check("imem_addr", bus.imem_addr, m_pc);
        check("id_valid", 32'(bus.id_valid), 32'(m_sv));
        check("halted", 32'(bus.halted), 32'(m_halted));
        check("err_misaligned", 32'(bus.err_misaligned), 32'(m_err));
        if (bus.id_valid && bus.id_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL scoreboard: unexpected handshake, got pc %h expected none", bus.id_pc);
            end else begin
                e = exp_q.pop_front();
                check("id_pc", bus.id_pc, e.pc);
                check("id_pc_plus4", bus.id_pc_plus4, e.pc + 32'd4);
                check("id_instr", bus.id_instr, e.instr);
            end
        end
    end

    // Wrap-around instance: free runs from 0xFFFF_FFF8 after the first reset.
    initial begin
        @(posedge rst_n);
        @(negedge clk);
        check("wrap valid0", 32'(bus2.id_valid), 32'h0);
        @(negedge clk);
        check("wrap valid1", 32'(bus2.id_valid), 32'h0);
        @(negedge clk);
        check("wrap valid2", 32'(bus2.id_valid), 32'h1);
        check("wrap pc0", bus2.id_pc, 32'hFFFF_FFF8);
        check("wrap instr0", bus2.id_instr, mem[62]);
        @(negedge clk);
        check("wrap pc1", bus2.id_pc, 32'hFFFF_FFFC);
        check("wrap pc1_plus4", bus2.id_pc_plus4, 32'h0000_0000);
        @(negedge clk);
        check("wrap pc2", bus2.id_pc, 32'h0000_0000);
        check("wrap err", 32'(bus2.err_misaligned), 32'h0);
    end

    // Stimulus: directed free-run, then random ready/redirect/reset traffic.
    initial begin
        logic [31:0] targets [8];
        int rst_hold;
        rst_hold = 0;
        targets[0] = 32'h0000_0020;
        targets[1] = 32'h0000_0022;
        targets[2] = 32'h0000_0028;
        targets[3] = 32'hFFFF_FFF8;
        targets[4] = 32'h0000_0000;
        targets[5] = 32'h0000_0004;
        targets[6] = 32'h0000_0100;
        targets[7] = 32'h0000_0030;
        for (int i = 0; i < 64; i++) begin
            mem[i] = $urandom;
            if (mem[i] == EBREAK_WORD) mem[i] = NOP_WORD;
        end
        mem[0]  = NOP_WORD;
        mem[1]  = 32'h0010_0093;
        mem[10] = EBREAK_WORD;

        model_reset();
        bus.id_ready        = 1'b1;
        bus.redirect_valid  = 1'b0;
        bus.redirect_target = 32'h0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #2;
            if (rst_n) model_step();

            if (rst_hold > 0) begin
                rst_hold--;
                if (rst_hold == 0) rst_n = 1'b1;
            end else if (c > 20 && $urandom_range(0, 39) == 0) begin
                rst_n = 1'b0;
                model_reset();
                exp_q.delete();
                rst_hold = 2;
            end

            if (c < 12) begin
                bus.id_ready       = 1'b1;
                bus.redirect_valid = 1'b0;
            end else begin
                bus.id_ready        = ($urandom_range(0, 3) != 0);
                bus.redirect_valid  = ($urandom_range(0, 9) == 0);
                if ($urandom_range(0, 2) == 0)
                    bus.redirect_target = {$urandom_range(0, 255), 2'b00};
                else
                    bus.redirect_target = targets[$urandom_range(0, 7)];
            end

            if (rst_n && m_sv && bus.id_ready) exp_q.push_back('{pc: m_spc, instr: m_sinstr});
        end

        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard drain: got %0d pending expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
